// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard for the ID stage.
// Counts in-flight writes per architectural register between the ID issue
// point and the WB writeback point, and raises a stall while an ID-stage
// source operand still has a pending write.
module reg_write_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2,
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic [IDX_W-1:0]    issue_dest,
    input  logic                freeze,
    input  logic [IDX_W-1:0]    src1,
    input  logic [IDX_W-1:0]    src2,
    input  logic                has_src2,
    input  logic                retire_valid,
    input  logic [IDX_W-1:0]    retire_dest,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy,
    output logic [3:0]          outstanding,
    output logic                err_overflow,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Indices at or beyond NUM_REGS are treated as "no register".
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < (IDX_W+1)'(NUM_REGS));
    endfunction

    // Busy lookup that reads as idle for an out-of-range index.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] b,
                                     input logic [IDX_W-1:0]    idx);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idx == IDX_W'(r)) hit = b[r];
        end
        return hit;
    endfunction

    // Saturating up/down step: simultaneous inc and dec cancel, a full
    // counter refuses to increment, an empty counter refuses to decrement.
    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic             inc,
                                                  input logic             dec);
        logic [CNT_W-1:0] n;
        n = c;
        if (inc && !dec && (c != CNT_MAX)) n = c + CNT_W'(1);
        else if (dec && !inc && (c != '0)) n = c - CNT_W'(1);
        return n;
    endfunction

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];

    logic             issue_fire;
    logic             inc_any;
    logic             dec_any;
    logic             same_reg;
    logic [CNT_W-1:0] inc_cnt;
    logic [CNT_W-1:0] dec_cnt;
    logic             inc_ok;
    logic             dec_ok;
    logic             ovf_set;
    logic             udf_set;

    // Per-register busy flags straight from the registered counters.
    always_comb begin
        busy = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    // Stall request: any real source operand with a pending write.
    always_comb begin
        hazard = busy_at(busy, src1) | (has_src2 & busy_at(busy, src2));
    end

    // Issue/retire qualification, acceptance and next counter values.
    always_comb begin
        issue_fire = issue_valid & issue_wb_en & ~freeze & ~hazard;
        inc_any    = issue_fire & idx_valid(issue_dest);
        dec_any    = retire_valid & idx_valid(retire_dest);
        same_reg   = inc_any & dec_any & (issue_dest == retire_dest);

        inc_cnt = '0;
        dec_cnt = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (issue_dest == IDX_W'(r))  inc_cnt = cnt[r];
            if (retire_dest == IDX_W'(r)) dec_cnt = cnt[r];
        end

        // A same-register issue+retire is a hold, so neither side is accepted.
        inc_ok  = inc_any & ~same_reg & (inc_cnt != CNT_MAX);
        dec_ok  = dec_any & ~same_reg & (dec_cnt != '0);
        ovf_set = inc_any & ~same_reg & (inc_cnt == CNT_MAX);
        udf_set = dec_any & ~same_reg & (dec_cnt == '0);

        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = cnt_step(cnt[r],
                                  inc_any && (issue_dest == IDX_W'(r)),
                                  dec_any && (retire_dest == IDX_W'(r)));
        end
    end

    // State update: counters, running total and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            outstanding   <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            outstanding   <= outstanding + {3'b000, inc_ok} - {3'b000, dec_ok};
            err_overflow  <= err_overflow | ovf_set;
            err_underflow <= err_underflow | udf_set;
        end
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: directed scenarios plus a
// randomized run against a count-per-register reference model.
module tb_reg_write_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_wb_en = 1'b0;
    logic [3:0]  issue_dest = '0;
    logic        freeze = 1'b0;
    logic [3:0]  src1 = '0;
    logic [3:0]  src2 = '0;
    logic        has_src2 = 1'b0;
    logic        retire_valid = 1'b0;
    logic [3:0]  retire_dest = '0;
    logic        hazard;
    logic [15:0] busy;
    logic [3:0]  outstanding;
    logic        err_overflow;
    logic        err_underflow;

    int checks = 0;
    int failures = 0;

    // Reference model: pending writes per register, sticky error bits.
    int mcnt [16];
    bit movf;
    bit mudf;

    reg_write_scoreboard #(.NUM_REGS(16), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
        .freeze(freeze), .src1(src1), .src2(src2), .has_src2(has_src2),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .hazard(hazard), .busy(busy), .outstanding(outstanding),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy(input int r);
        return mcnt[r] > 0;
    endfunction

    function automatic bit m_hazard();
        return m_busy(int'(src1)) || (has_src2 && m_busy(int'(src2)));
    endfunction

    function automatic logic [15:0] m_busyvec();
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = m_busy(r);
        return v;
    endfunction

    // Outstanding is the total of all pending writes, seen through a 4-bit port.
    function automatic logic [3:0] m_out();
        int s;
        s = 0;
        for (int r = 0; r < 16; r++) s += mcnt[r];
        return 4'(s);
    endfunction

    // Advance one clock: apply the spec rules to the model with the inputs
    // present before the edge, then sample the DUT 1 time unit after it.
    task automatic clk_step();
        int i;
        int d;
        if (rst) begin
            for (int r = 0; r < 16; r++) mcnt[r] = 0;
            movf = 0;
            mudf = 0;
        end else begin
            i = (issue_valid && issue_wb_en && !freeze && !m_hazard()) ? int'(issue_dest) : -1;
            d = retire_valid ? int'(retire_dest) : -1;
            if (!(i >= 0 && i == d)) begin
                if (i >= 0) begin
                    if (mcnt[i] == 3) movf = 1;
                    else mcnt[i] += 1;
                end
                if (d >= 0) begin
                    if (mcnt[d] == 0) mudf = 1;
                    else mcnt[d] -= 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; issue_wb_en = 1'b0; issue_dest = '0;
        freeze = 1'b0; src1 = '0; src2 = '0; has_src2 = 1'b0;
        retire_valid = 1'b0; retire_dest = '0;
    endtask

    task automatic issue(input logic [3:0] r);
        issue_valid = 1'b1; issue_wb_en = 1'b1; issue_dest = r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1'($urandom); issue_wb_en = 1'($urandom); issue_dest = 4'($urandom);
        freeze = 1'($urandom); src1 = 4'($urandom); src2 = 4'($urandom);
        has_src2 = 1'($urandom); retire_valid = 1'($urandom); retire_dest = 4'($urandom);
        clk_step();
        idle();
        #1;
        checks++;
        if (busy !== 16'h0000 || hazard !== 1'b0 || outstanding !== 4'd0 ||
            err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%h hazard=%b out=%0d ovf=%b udf=%b, required all zero",
                     busy, hazard, outstanding, err_overflow, err_underflow);
        end
    endtask

    task automatic test_dependency();
        idle();
        issue(4'd3);
        clk_step();
        issue_valid = 1'b0;
        src1 = 4'd3;
        #1;
        checks++;
        if (hazard !== 1'b1 || busy !== 16'h0008) begin
            failures++;
            $display("FAIL dep_set: hazard=%b busy=%h, required 1 0008", hazard, busy);
        end
        clk_step();
        clk_step();
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL dep_hold: hazard=%b, required 1", hazard);
        end
        retire_valid = 1'b1; retire_dest = 4'd3;
        clk_step();
        retire_valid = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0 || outstanding !== 4'd0) begin
            failures++;
            $display("FAIL dep_clear: hazard=%b out=%0d, required 0 0", hazard, outstanding);
        end
    endtask

    task automatic test_double_issue();
        idle();
        issue(4'd5);
        clk_step();
        issue_wb_en = 1'b0; issue_dest = 4'd9; src1 = 4'd1;
        clk_step();
        issue(4'd5); src1 = 4'd0;
        clk_step();
        issue_valid = 1'b0;
        checks++;
        if (busy[5] !== 1'b1 || outstanding !== 4'd2 || busy[9] !== 1'b0) begin
            failures++;
            $display("FAIL double_issue: busy=%h out=%0d, required busy 0020 out 2", busy, outstanding);
        end
        retire_valid = 1'b1; retire_dest = 4'd5;
        clk_step();
        checks++;
        if (busy[5] !== 1'b1 || outstanding !== 4'd1) begin
            failures++;
            $display("FAIL retire_once: busy5=%b out=%0d, required 1 1", busy[5], outstanding);
        end
        clk_step();
        retire_valid = 1'b0;
        checks++;
        if (busy[5] !== 1'b0 || outstanding !== 4'd0) begin
            failures++;
            $display("FAIL retire_twice: busy5=%b out=%0d, required 0 0", busy[5], outstanding);
        end
    endtask

    task automatic test_same_cycle();
        idle();
        issue(4'd2);
        clk_step();
        retire_valid = 1'b1; retire_dest = 4'd2;
        clk_step();
        issue_valid = 1'b0; retire_valid = 1'b0;
        checks++;
        if (busy !== 16'h0004 || outstanding !== 4'd1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle: busy=%h out=%0d ovf=%b udf=%b, required 0004 1 0 0",
                     busy, outstanding, err_overflow, err_underflow);
        end
        retire_valid = 1'b1;
        clk_step();
        retire_valid = 1'b0;
        checks++;
        if (outstanding !== 4'd0 || busy !== 16'h0000) begin
            failures++;
            $display("FAIL same_cycle_drain: busy=%h out=%0d, required 0000 0", busy, outstanding);
        end
    endtask

    task automatic test_freeze_src2();
        idle();
        freeze = 1'b1;
        issue(4'd7);
        clk_step();
        freeze = 1'b0; issue_valid = 1'b0;
        checks++;
        if (busy[7] !== 1'b0 || outstanding !== 4'd0) begin
            failures++;
            $display("FAIL freeze: busy7=%b out=%0d, required 0 0", busy[7], outstanding);
        end
        issue(4'd8);
        clk_step();
        issue_valid = 1'b0; src1 = 4'd0; src2 = 4'd8; has_src2 = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin
            failures++;
            $display("FAIL no_src2: hazard=%b, required 0", hazard);
        end
        has_src2 = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b1) begin
            failures++;
            $display("FAIL src2: hazard=%b, required 1", hazard);
        end
        issue(4'd10);
        clk_step();
        issue_valid = 1'b0;
        checks++;
        if (busy[10] !== 1'b0 || outstanding !== 4'd1) begin
            failures++;
            $display("FAIL stall_blocks_issue: busy10=%b out=%0d, required 0 1", busy[10], outstanding);
        end
        has_src2 = 1'b0;
        retire_valid = 1'b1; retire_dest = 4'd8;
        clk_step();
        retire_valid = 1'b0;
    endtask

    task automatic test_errors();
        idle();
        retire_valid = 1'b1; retire_dest = 4'd9;
        clk_step();
        retire_valid = 1'b0;
        checks++;
        if (err_underflow !== 1'b1 || busy[9] !== 1'b0 || outstanding !== 4'd0) begin
            failures++;
            $display("FAIL underflow: udf=%b busy9=%b out=%0d, required 1 0 0", err_underflow, busy[9], outstanding);
        end
        issue(4'd4);
        for (int k = 0; k < 3; k++) clk_step();
        checks++;
        if (err_overflow !== 1'b0 || outstanding !== 4'd3) begin
            failures++;
            $display("FAIL pre_overflow: ovf=%b out=%0d, required 0 3", err_overflow, outstanding);
        end
        clk_step();
        issue_valid = 1'b0;
        checks++;
        if (err_overflow !== 1'b1 || outstanding !== 4'd3 || busy !== 16'h0010 || err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow: ovf=%b out=%0d busy=%h udf=%b, required 1 3 0010 1",
                     err_overflow, outstanding, busy, err_underflow);
        end
        rst = 1'b1;
        clk_step();
        rst = 1'b0;
        checks++;
        if (busy !== 16'h0000 || outstanding !== 4'd0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: busy=%h out=%0d ovf=%b udf=%b, required all zero",
                     busy, outstanding, err_overflow, err_underflow);
        end
    endtask

    task automatic test_random();
        int cand;
        idle();
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 59) == 0);
            issue_valid  = 1'($urandom);
            issue_wb_en  = ($urandom_range(0, 3) != 0);
            issue_dest   = 4'($urandom);
            freeze       = ($urandom_range(0, 7) == 0);
            src1         = 4'($urandom);
            src2         = 4'($urandom);
            has_src2     = 1'($urandom);
            retire_valid = ($urandom_range(0, 9) < 6);
            retire_dest  = 4'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                cand = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++) begin
                    if (mcnt[(cand + k) % 16] > 0) begin
                        retire_dest = 4'((cand + k) % 16);
                        break;
                    end
                end
            end
            clk_step();
            checks++;
            if (busy !== m_busyvec() || hazard !== m_hazard() || outstanding !== m_out() ||
                err_overflow !== movf || err_underflow !== mudf) begin
                failures++;
                $display("FAIL random[%0d]: busy=%h hz=%b out=%0d ovf=%b udf=%b, required %h %b %0d %b %b",
                         n, busy, hazard, outstanding, err_overflow, err_underflow,
                         m_busyvec(), m_hazard(), m_out(), movf, mudf);
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 16; r++) mcnt[r] = 0;
        movf = 0;
        mudf = 0;
        test_reset();
        test_dependency();
        test_double_issue();
        test_same_cycle();
        test_freeze_src2();
        test_errors();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
